sensors_aggregator: RTL and testbench
=====================================

SENSORS_AGGREGATOR -- requirements
Module: sensors_aggregator

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 4, number of sensor channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, width of each reading and of height.
REQ-003 SHALL derive localparam SUM_W = DATA_W + clog2(NUM_SENSORS) and CNT_W = clog2(NUM_SENSORS+1).
REQ-004 clk  input  1  single clock, all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  the sensor vector is presented.
REQ-007 in_ready  output  1  block accepts a vector.
REQ-008 sensors  input  NUM_SENSORS*DATA_W  packed readings, channel i at bits [i*DATA_W +: DATA_W].
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 height  output  DATA_W  rounded mean of the non-zero readings.
REQ-012 valid_count  output  CNT_W  number of non-zero readings used.
REQ-013 all_invalid  output  1  every reading was zero.

Function
REQ-014 A reading of 0 SHALL mean a faulty sensor and SHALL be excluded from the sum and the count.
REQ-015 The FSM SHALL have the states IDLE, ACCUM, DIVIDE and OUTPUT.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready SHALL register sensors, clear sum/count/index and go to ACCUM.
REQ-017 ACCUM SHALL examine one channel per cycle, index 0..NUM_SENSORS-1, adding non-zero readings into the SUM_W-bit sum and incrementing the count.
REQ-018 After the last channel, count==0 SHALL go directly to OUTPUT with height=0 and all_invalid=1; otherwise the FSM SHALL go to DIVIDE.
REQ-019 DIVIDE SHALL compute height = (sum + (count>>1)) / count, i.e. round half-up, as a restoring division at one quotient bit per cycle for exactly SUM_W cycles.
REQ-020 The quotient SHALL always fit in DATA_W bits and SHALL be truncated to DATA_W bits without a saturation path.
REQ-021 Latency: with the accept edge at t0, out_valid SHALL rise at t0+NUM_SENSORS+SUM_W+1, or at t0+NUM_SENSORS+1 when count==0.
REQ-022 OUTPUT: out_valid=1 and height/valid_count/all_invalid SHALL be held stable until out_valid&&out_ready, then the FSM SHALL go to IDLE.
REQ-023 in_ready SHALL be 0 outside IDLE; there is no overlap of the input and output phases (one vector in flight).
REQ-024 out_valid SHALL be 0 outside OUTPUT; height SHALL keep its last value after the handshake until the next result.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, and height, valid_count, all_invalid, out_valid, sum, count and index to 0.
REQ-026 Reset during ACCUM/DIVIDE/OUTPUT SHALL discard the vector in flight, with no result emitted after release.
REQ-027 The first accept after release SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-028 Macro SENSORS_AGGREGATOR_HOLD_EN: when defined, an all-zero vector SHALL output the last good height (0 if none since reset) with all_invalid=1 and valid_count=0.
REQ-029 When the macro is undefined, an all-zero vector SHALL output height=0 (REQ-018); the last-good register SHALL not exist.

Structure
REQ-030 Shared package sensors_pkg SHALL hold the FSM state typedef (2-bit encoding), DEFAULT_NUM_SENSORS=4, DEFAULT_DATA_W=8 and a clog2 function.
REQ-031 The division SHALL live in the sub-module seq_divider (start/done, SUM_W dividend, CNT_W divisor, SUM_W cycles).

Verification
REQ-032 Readings 140,138,139,140 -> height=139, valid_count=4, all_invalid=0, out_valid at t0+15 (N=4, W=8).
REQ-033 Readings 0,138,139,140 -> height=139 ((417+1)/3), valid_count=3; readings 140,0,139,0 -> height=140, valid_count=2.
REQ-034 All readings 0 -> height=0, all_invalid=1, out_valid at t0+5; with HOLD_EN after the REQ-032 case -> height=139.
REQ-035 All readings 255 -> height=255, with no overflow of sum (1020 fits in 10 bits).
REQ-036 out_ready held low for 5 cycles in OUTPUT -> out_valid, height and valid_count stable, in_ready=0; in_valid pulses ignored.
REQ-037 rst_n pulsed low in the DIVIDE phase -> outputs 0 at once, no out_valid afterwards; the next vector 10,20,30,40 -> height=25.

Source files
------------

// File: rtl/sensors_pkg.sv
// Shared definitions for the sensor aggregator: FSM state encoding,
// default sizing parameters and a ceiling-log2 helper for width derivation.
package sensors_pkg;

    localparam int DEFAULT_NUM_SENSORS = 4;
    localparam int DEFAULT_DATA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle for exactly SUM_W
// cycles after start. done_o is asserted during the final step cycle and
// quotient_o carries the completed quotient in that same cycle, so the
// caller can register the result on the edge that finishes the division.
module seq_divider
    import sensors_pkg::*;
#(
    parameter int SUM_W = 10,
    parameter int CNT_W = 3,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             done_o,
    output logic [Q_W-1:0]   quotient_o
);

    localparam int CB = clog2(SUM_W + 1);
    localparam logic [CB-1:0] CNT_ONE  = {{(CB-1){1'b0}}, 1'b1};
    localparam logic [CB-1:0] CNT_LOAD = CB'(SUM_W);

    logic [SUM_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CB-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [CNT_W:0]   rem_shift_s;
    logic [CNT_W:0]   rem_diff_s;
    logic             q_bit_s;
    logic [SUM_W-1:0] quo_step_s;
    logic [CNT_W-1:0] rem_step_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[SUM_W-1]};
        rem_diff_s  = rem_shift_s - {1'b0, div_q};
        if (rem_shift_s >= {1'b0, div_q}) begin
            q_bit_s    = 1'b1;
            rem_step_s = rem_diff_s[CNT_W-1:0];
        end else begin
            q_bit_s    = 1'b0;
            rem_step_s = rem_shift_s[CNT_W-1:0];
        end
        quo_step_s = {quo_q[SUM_W-2:0], q_bit_s};
    end

    // Load on start, step while busy, stop after the last quotient bit.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = {CNT_W{1'b0}};
            div_d  = divisor_i;
            cnt_d  = CNT_LOAD;
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = quo_step_s;
            rem_d = rem_step_s;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= {SUM_W{1'b0}};
            rem_q  <= {CNT_W{1'b0}};
            div_q  <= {CNT_W{1'b0}};
            cnt_q  <= {CB{1'b0}};
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o     = busy_q && (cnt_q == CNT_ONE);
    assign quotient_o = quo_step_s[Q_W-1:0];

endmodule

// File: rtl/sensors_aggregator.sv
// Sensor aggregator: accepts a vector of readings, drops zero (faulty)
// readings, and returns the round-half-up mean of the rest together with the
// number of readings used. One vector is in flight at a time.
// Optional build macro SENSORS_AGGREGATOR_HOLD_EN: an all-zero vector reports
// the last good height instead of 0.
module sensors_aggregator
    import sensors_pkg::*;
#(
    parameter int NUM_SENSORS = DEFAULT_NUM_SENSORS,
    parameter int DATA_W      = DEFAULT_DATA_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_SENSORS*DATA_W-1:0]   sensors,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               height,
    output logic [clog2(NUM_SENSORS+1)-1:0] valid_count,
    output logic                            all_invalid
);

    localparam int SUM_W = DATA_W + clog2(NUM_SENSORS);
    localparam int CNT_W = clog2(NUM_SENSORS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SENSORS);

    state_t                          state_q, state_d;
    logic [NUM_SENSORS*DATA_W-1:0]   sensors_q, sensors_d;
    logic [SUM_W-1:0]                sum_q, sum_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic [DATA_W-1:0]               height_q, height_d;
    logic [CNT_W-1:0]                valid_count_q, valid_count_d;
    logic                            all_invalid_q, all_invalid_d;

    logic [DATA_W-1:0]               cur_reading_s;
    logic [DATA_W-1:0]               hold_height_s;
    logic [SUM_W-1:0]                dividend_s;
    logic                            div_start_s;
    logic                            div_done_s;
    logic [DATA_W-1:0]               div_quo_s;

    // The channel under examination always sits in the low slot of the shifted copy.
    assign cur_reading_s = sensors_q[DATA_W-1:0];
    // Adding half the divisor before dividing gives round-half-up.
    assign dividend_s    = sum_q + {{(SUM_W-CNT_W+1){1'b0}}, count_q[CNT_W-1:1]};

`ifdef SENSORS_AGGREGATOR_HOLD_EN
    logic [DATA_W-1:0] last_good_q, last_good_d;

    // Remember the most recent height computed from real readings.
    always_comb begin
        last_good_d = last_good_q;
        if ((state_q == ST_DIVIDE) && div_done_s) begin
            last_good_d = div_quo_s;
        end else begin
            last_good_d = last_good_q;
        end
    end

    // Last-good height register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_good_q <= {DATA_W{1'b0}};
        end else begin
            last_good_q <= last_good_d;
        end
    end

    assign hold_height_s = last_good_q;
`else
    assign hold_height_s = {DATA_W{1'b0}};
`endif

    // Next-state and datapath control for the accept/accumulate/divide/output sequence.
    always_comb begin
        state_d       = state_q;
        sensors_d     = sensors_q;
        sum_d         = sum_q;
        count_d       = count_q;
        idx_d         = idx_q;
        height_d      = height_q;
        valid_count_d = valid_count_q;
        all_invalid_d = all_invalid_q;
        div_start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sensors_d = sensors;
                    sum_d     = {SUM_W{1'b0}};
                    count_d   = {CNT_W{1'b0}};
                    idx_d     = {CNT_W{1'b0}};
                    state_d   = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (idx_q == LAST_IDX) begin
                    // All channels seen: decide between empty result and division.
                    if (count_q == {CNT_W{1'b0}}) begin
                        height_d      = hold_height_s;
                        valid_count_d = {CNT_W{1'b0}};
                        all_invalid_d = 1'b1;
                        state_d       = ST_OUTPUT;
                    end else begin
                        div_start_s = 1'b1;
                        state_d     = ST_DIVIDE;
                    end
                end else begin
                    if (cur_reading_s != {DATA_W{1'b0}}) begin
                        sum_d   = sum_q + {{(SUM_W-DATA_W){1'b0}}, cur_reading_s};
                        count_d = count_q + CNT_ONE;
                    end else begin
                        sum_d   = sum_q;
                        count_d = count_q;
                    end
                    sensors_d = {{DATA_W{1'b0}}, sensors_q[NUM_SENSORS*DATA_W-1:DATA_W]};
                    idx_d     = idx_q + CNT_ONE;
                end
            end
            ST_DIVIDE: begin
                if (div_done_s) begin
                    height_d      = div_quo_s;
                    valid_count_d = count_q;
                    all_invalid_d = 1'b0;
                    state_d       = ST_OUTPUT;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sensors_q     <= {(NUM_SENSORS*DATA_W){1'b0}};
            sum_q         <= {SUM_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            idx_q         <= {CNT_W{1'b0}};
            height_q      <= {DATA_W{1'b0}};
            valid_count_q <= {CNT_W{1'b0}};
            all_invalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sensors_q     <= sensors_d;
            sum_q         <= sum_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            height_q      <= height_d;
            valid_count_q <= valid_count_d;
            all_invalid_q <= all_invalid_d;
        end
    end

    seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W),
        .Q_W   (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_s),
        .dividend_i (dividend_s),
        .divisor_i  (count_q),
        .done_o     (div_done_s),
        .quotient_o (div_quo_s)
    );

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_OUTPUT);
    assign height      = height_q;
    assign valid_count = valid_count_q;
    assign all_invalid = all_invalid_q;

endmodule

// File: tb/tb_sensors_aggregator.sv
// Self-checking bench for sensors_aggregator: a reference model pushes the
// expected result of each accepted vector into a scoreboard queue, which is
// popped and compared when the DUT presents its result.
module tb_sensors_aggregator;
    import sensors_pkg::*;

    localparam int N     = DEFAULT_NUM_SENSORS;
    localparam int W     = DEFAULT_DATA_W;
    localparam int SUM_W = W + clog2(N);
    localparam int CNT_W = clog2(N + 1);

    typedef struct {
        int height;
        int count;
        int all_inv;
        int latency;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   sensors;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     height;
    logic [CNT_W-1:0] valid_count;
    logic             all_invalid;

    exp_t sb_q[$];
    int   assert_cnt;
    int   fail_cnt;
    int   cyc;
    int   model_last_good;

    sensors_aggregator #(
        .NUM_SENSORS (N),
        .DATA_W      (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sensors     (sensors),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .height      (height),
        .valid_count (valid_count),
        .all_invalid (all_invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int observed, input int expected);
        assert_cnt++;
        if (observed != expected) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: mean of non-zero readings, round half-up.
    task automatic model_push(input logic [N*W-1:0] vec);
        exp_t e;
        int   sum;
        int   cnt;
        int   r;
        sum = 0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            r = int'(vec[i*W +: W]);
            if (r != 0) begin
                sum += r;
                cnt++;
            end
        end
        e.count = cnt;
        if (cnt == 0) begin
`ifdef SENSORS_AGGREGATOR_HOLD_EN
            e.height = model_last_good;
`else
            e.height = 0;
`endif
            e.all_inv = 1;
            e.latency = N + 1;
        end else begin
            e.height        = ((sum + cnt / 2) / cnt) % (1 << W);
            e.all_inv       = 0;
            e.latency       = N + SUM_W + 1;
            model_last_good = e.height;
        end
        sb_q.push_back(e);
    endtask

    task automatic run_vector(input logic [N*W-1:0] vec, input int stall);
        exp_t e;
        int   t0;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("in_ready_before_accept", int'(in_ready), 1);
        sensors  = vec;
        in_valid = 1'b1;
        model_push(vec);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t0       = cyc;
        waited   = 0;
        while (!out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            check_eq("out_valid_timeout", 0, 1);
            return;
        end
        check_eq("latency", cyc - t0, e.latency);
        check_eq("height", int'(height), e.height);
        check_eq("valid_count", int'(valid_count), e.count);
        check_eq("all_invalid", int'(all_invalid), e.all_inv);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_eq("stall_out_valid", int'(out_valid), 1);
            check_eq("stall_height", int'(height), e.height);
            check_eq("stall_valid_count", int'(valid_count), e.count);
            check_eq("stall_in_ready", int'(in_ready), 0);
            sensors  = ~vec;
            in_valid = ((k % 2) == 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_out_valid", int'(out_valid), 0);
        check_eq("post_in_ready", int'(in_ready), 1);
        check_eq("post_height_hold", int'(height), e.height);
    endtask

    initial begin
        logic [N*W-1:0] vec;
        int             ov_seen;
        clk             = 1'b0;
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        sensors         = '0;
        cyc             = 0;
        assert_cnt      = 0;
        fail_cnt        = 0;
        model_last_good = 0;

        #12;
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_in_ready", int'(in_ready), 1);
        check_eq("reset_height", int'(height), 0);
        check_eq("reset_valid_count", int'(valid_count), 0);
        check_eq("reset_all_invalid", int'(all_invalid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Channel 0 is the least significant slot.
        run_vector({8'd140, 8'd139, 8'd138, 8'd140}, 0);
        run_vector({8'd140, 8'd139, 8'd138, 8'd0}, 0);
        run_vector({8'd0, 8'd139, 8'd0, 8'd140}, 0);
        run_vector({8'd0, 8'd0, 8'd0, 8'd0}, 0);
        run_vector({8'd255, 8'd255, 8'd255, 8'd255}, 0);
        run_vector({8'd40, 8'd30, 8'd20, 8'd10}, 5);

        // Reset while dividing: vector is dropped, outputs clear at once.
        @(negedge clk);
        sensors  = {8'd200, 8'd100, 8'd50, 8'd25};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (N + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_height", int'(height), 0);
        check_eq("rst_mid_valid_count", int'(valid_count), 0);
        check_eq("rst_mid_out_valid", int'(out_valid), 0);
        model_last_good = 0;
        @(negedge clk);
        rst_n   = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < SUM_W + N + 5; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
        end
        check_eq("no_result_after_reset", ov_seen, 0);
        run_vector({8'd40, 8'd30, 8'd20, 8'd10}, 0);

        // Random vectors with a sprinkling of faulty channels.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) vec[i*W +: W] = '0;
                else vec[i*W +: W] = W'($urandom_range(1, 255));
            end
            run_vector(vec, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
